// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences load and compute selects for the Parallel_module convolution datapath
module conv_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step_en,
  input  logic       abort,
  input  logic [7:0] out,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic       we_1,
  output logic       we_2,
  output logic       preset,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [63:0] S0_TAB = {4'd7, 4'd6, 4'd5, 4'd3, 4'd2, 4'd1, 4'd6, 4'd5,
                                    4'd4, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  state_t     state_q, state_d;
  logic [3:0] k_q, k_d, s0_d, s1_d;
  logic       we_1_d, we_2_d, busy_d, done_d;
  logic [7:0] result_d;
  assign preset = 1'b0;
  // next state and step index; outputs are decoded from the next state so they register with it
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    if (abort) begin
      state_d = IDLE;
      k_d = 4'd0;
    end else if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d = LOAD;
      k_d = 4'd0;
    end else if ((state_q == LOAD || state_q == RUN) && step_en) begin
      state_d = (k_q == 4'd15) ? DONE : (k_q == 4'd3) ? RUN : state_q;
      k_d = (k_q == 4'd15) ? k_q : k_q + 4'd1;
    end
    s0_d = (state_d == RUN) ? S0_TAB[{k_d, 2'b00} +: 4] : (state_d == DONE) ? 4'd7 : 4'd0;
    s1_d = (state_d == LOAD) ? ((k_d == 4'd0) ? 4'd2 : (k_d == 4'd1) ? 4'd1 : 4'd0) : 4'd0;
    we_1_d = (state_d == LOAD) && (k_d == 4'd1 || k_d == 4'd2);
    we_2_d = (state_d == LOAD) && (k_d == 4'd3);
    busy_d = (state_d == LOAD) || (state_d == RUN);
    done_d = (state_d == DONE) && (state_q != DONE);
    result_d = done_d ? out : result;
  end
  // state and registered outputs with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= 4'd0;
      s0 <= 4'd0;
      s1 <= 4'd0;
      we_1 <= 1'b0;
      we_2 <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= 8'd0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      s0 <= s0_d;
      s1 <= s1_d;
      we_1 <= we_1_d;
      we_2 <= we_2_d;
      busy <= busy_d;
      done <= done_d;
      result <= result_d;
    end
  end
endmodule
